// File: rtl/seven_segment_capture.sv
// Receive side of a scanned 8-digit seven-segment bus: rebuilds the displayed 32-bit hex value
// from the active-low anode/cathode lines and publishes it once per complete in-order frame.
module seven_segment_capture #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [6:0]  cat_in,
    input  logic [7:0]  an_in,
    output logic [31:0] val_out,
    output logic        valid_out,
    output logic        err_out
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {SYNC, COLLECT, PUBLISH} state_t;

    state_t        state_q, state_d;
    logic [7:0]    an_q;
    logic [6:0]    cat_q;
    logic [14:0]   prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          taken_q;
    logic [31:0]   frame_q, frame_d;
    logic [2:0]    expect_q, expect_d;
    logic          publish_d, err_d;

    logic [6:0]    seg;
    logic [7:0]    sel;
    logic          same, stable, new_dwell;
    logic          blank, one_hot;
    logic [2:0]    digit;
    logic [4:0]    dec;
    logic          legal;
    logic [3:0]    nib;

    // Returns {legal, nibble}; any pattern outside the sixteen hex glyphs is illegal.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F:   decode = 5'h10;
            7'h06:   decode = 5'h11;
            7'h5B:   decode = 5'h12;
            7'h4F:   decode = 5'h13;
            7'h66:   decode = 5'h14;
            7'h6D:   decode = 5'h15;
            7'h7D:   decode = 5'h16;
            7'h07:   decode = 5'h17;
            7'h7F:   decode = 5'h18;
            7'h6F:   decode = 5'h19;
            7'h77:   decode = 5'h1A;
            7'h7C:   decode = 5'h1B;
            7'h39:   decode = 5'h1C;
            7'h5E:   decode = 5'h1D;
            7'h79:   decode = 5'h1E;
            7'h71:   decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    function automatic logic [2:0] digit_index(input logic [7:0] s);
        digit_index = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (s[i]) digit_index = 3'(i);
        end
    endfunction

    assign seg     = ~cat_q;
    assign sel     = ~an_q;
    assign same    = ({an_q, cat_q} == prev_q);
    assign blank   = (sel == 8'd0);
    assign one_hot = $onehot(sel);
    assign digit   = digit_index(sel);
    assign dec     = decode(seg);
    assign legal   = dec[4];
    assign nib     = dec[3:0];

    // Run length of the current sample, saturating; a dwell is acted on only once.
    always_comb begin
        cnt_d = '0;
        if (same) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    assign stable    = (cnt_d == CNT_MAX);
    assign new_dwell = stable && !(same && taken_q);

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        expect_d  = expect_q;
        publish_d = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            SYNC: begin
                if (new_dwell && one_hot && digit == 3'd0 && legal) begin
                    frame_d  = {28'd0, nib};
                    expect_d = 3'd1;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (new_dwell && !blank) begin
                    if (one_hot && digit == expect_q && legal) begin
                        frame_d[{digit, 2'b00} +: 4] = nib;
                        if (digit == 3'd7) state_d = PUBLISH;
                        else expect_d = expect_q + 3'd1;
                    end else if (one_hot && digit == expect_q - 3'd1) begin
                        // Previous digit settling again after a glitch: not a protocol error.
                        state_d = COLLECT;
                    end else begin
                        err_d   = 1'b1;
                        frame_d = '0;
                        state_d = SYNC;
                    end
                end
            end
            PUBLISH: begin
                publish_d = 1'b1;
                state_d   = SYNC;
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            an_q      <= '1;
            cat_q     <= '1;
            prev_q    <= '1;
            cnt_q     <= '0;
            taken_q   <= 1'b0;
            state_q   <= SYNC;
            frame_q   <= '0;
            expect_q  <= '0;
            val_out   <= '0;
            valid_out <= 1'b0;
            err_out   <= 1'b0;
        end else begin
            an_q      <= an_in;
            cat_q     <= cat_in;
            prev_q    <= {an_q, cat_q};
            cnt_q     <= cnt_d;
            taken_q   <= stable;
            state_q   <= state_d;
            frame_q   <= frame_d;
            expect_q  <= expect_d;
            if (publish_d) val_out <= frame_q;
            valid_out <= publish_d;
            err_out   <= err_d;
        end
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture: drives hand-built scan frames and checks published values and pulses.
module tb_seven_segment_capture;

    localparam int SETTLE = 4;
    localparam int DWELL  = 16;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [6:0]  cat_in;
    logic [7:0]  an_in;
    logic [31:0] val_out;
    logic        valid_out;
    logic        err_out;

    int total = 0;
    int bad = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;
    int last_lat = -1;
    logic [31:0] last_val = '0;

    seven_segment_capture #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .cat_in   (cat_in),
        .an_in    (an_in),
        .val_out  (val_out),
        .valid_out(valid_out),
        .err_out  (err_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (valid_out) begin
            n_valid  <= n_valid + 1;
            last_val <= val_out;
        end
        if (err_out) n_err <= n_err + 1;
        if (valid_out && err_out) n_both <= n_both + 1;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 7'h3F;  4'h1: seg_of = 7'h06;  4'h2: seg_of = 7'h5B;  4'h3: seg_of = 7'h4F;
            4'h4: seg_of = 7'h66;  4'h5: seg_of = 7'h6D;  4'h6: seg_of = 7'h7D;  4'h7: seg_of = 7'h07;
            4'h8: seg_of = 7'h7F;  4'h9: seg_of = 7'h6F;  4'hA: seg_of = 7'h77;  4'hB: seg_of = 7'h7C;
            4'hC: seg_of = 7'h39;  4'hD: seg_of = 7'h5E;  4'hE: seg_of = 7'h79;  default: seg_of = 7'h71;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Holds the pins for a number of cycles and notes how many edges until valid_out appeared.
    task automatic applyStimulus(input logic [7:0] an, input logic [6:0] cat, input int cycles);
        an_in    = an;
        cat_in   = cat;
        last_lat = -1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_in);
            #1;
            if (valid_out && last_lat < 0) last_lat = i + 1;
        end
    endtask

    task automatic send_digit(input int k, input logic [3:0] nib, input int cycles);
        logic [7:0] an;
        an = ~(8'b1 << k);
        applyStimulus(an, ~seg_of(nib), cycles);
    endtask

    task automatic send_frame(input logic [31:0] v);
        for (int k = 0; k < 8; k++) send_digit(k, v[4*k +: 4], DWELL);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst_in = 1'b1;
        an_in  = 8'hFF;
        cat_in = 7'h7F;
        repeat (3) @(posedge clk_in);
        #1;
        checkOutput("rst_val", val_out, 32'h0);
        checkOutput("rst_valid", {31'd0, valid_out}, 32'd0);
        checkOutput("rst_err", {31'd0, err_out}, 32'd0);
        rst_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;

        $display("[TB] back-to-back frames");
        send_frame(32'h1234_ABCD);
        send_frame(32'h1234_ABCD);
        checkOutput("t1_latency", last_lat, SETTLE + 2);
        checkOutput("t1_nvalid", n_valid, 2);
        checkOutput("t1_val", val_out, 32'h1234_ABCD);
        checkOutput("t1_last", last_val, 32'h1234_ABCD);
        checkOutput("t1_nerr", n_err, 0);

        $display("[TB] value change mid-frame");
        a = 32'h1234_ABCD;
        b = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) send_digit(k, a[4*k +: 4], DWELL);
        for (int k = 4; k < 8; k++) send_digit(k, b[4*k +: 4], DWELL);
        checkOutput("t2_mix_nvalid", n_valid, 3);
        checkOutput("t2_mix_val", last_val, 32'hDEAD_ABCD);
        send_frame(32'hDEAD_BEEF);
        checkOutput("t2_nvalid", n_valid, 4);
        checkOutput("t2_val", val_out, 32'hDEAD_BEEF);

        $display("[TB] illegal code on digit 3");
        a = 32'h0F1E_2D3C;
        for (int k = 0; k < 3; k++) send_digit(k, a[4*k +: 4], DWELL);
        applyStimulus(8'b1111_0111, ~7'h01, 20);
        for (int k = 4; k < 8; k++) send_digit(k, a[4*k +: 4], DWELL);
        checkOutput("t3_nerr", n_err, 1);
        checkOutput("t3_nvalid", n_valid, 4);
        checkOutput("t3_hold", val_out, 32'hDEAD_BEEF);
        send_frame(a);
        checkOutput("t3_rec_nvalid", n_valid, 5);
        checkOutput("t3_rec_val", val_out, 32'h0F1E_2D3C);

        $display("[TB] out-of-order and multi-hot anodes");
        send_digit(0, 4'h1, DWELL);
        send_digit(1, 4'h2, DWELL);
        send_digit(2, 4'h3, DWELL);
        send_digit(5, 4'h4, DWELL);
        checkOutput("t4_order_err", n_err, 2);
        send_digit(0, 4'h1, DWELL);
        applyStimulus(8'b1111_1100, ~seg_of(4'h2), DWELL);
        checkOutput("t4_multi_err", n_err, 3);
        checkOutput("t4_nvalid", n_valid, 5);

        $display("[TB] glitch and blank gap");
        a = 32'h89AB_CDEF;
        for (int k = 0; k < 4; k++) send_digit(k, a[4*k +: 4], DWELL);
        applyStimulus(8'b1110_1111, ~seg_of(4'hB), 8);
        applyStimulus(8'b1110_1111, ~seg_of(4'h3), 2);
        applyStimulus(8'b1110_1111, ~seg_of(4'hB), 12);
        send_digit(5, 4'hA, DWELL);
        applyStimulus(8'hFF, 7'h7F, 10);
        send_digit(6, 4'h9, DWELL);
        send_digit(7, 4'h8, DWELL);
        checkOutput("t5_nerr", n_err, 3);
        checkOutput("t5_nvalid", n_valid, 6);
        checkOutput("t5_val", val_out, 32'h89AB_CDEF);

        $display("[TB] reset mid-frame");
        a = 32'h55AA_33CC;
        for (int k = 0; k < 5; k++) send_digit(k, a[4*k +: 4], DWELL);
        send_digit(5, 4'hA, 5);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        checkOutput("t6_rst_val", val_out, 32'h0);
        checkOutput("t6_rst_valid", {31'd0, valid_out}, 32'd0);
        send_digit(5, 4'hA, 10);
        send_digit(6, 4'h5, DWELL);
        send_digit(7, 4'h5, DWELL);
        checkOutput("t6_no_valid", n_valid, 6);
        checkOutput("t6_hold_zero", val_out, 32'h0);
        send_frame(32'h7654_3210);
        checkOutput("t6_nvalid", n_valid, 7);
        checkOutput("t6_val", val_out, 32'h7654_3210);
        checkOutput("t6_nerr", n_err, 3);

        checkOutput("overlap", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
